// File: rtl/alu_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_arbiter_if
// Purpose  : Handshake bundle between two ALU requesters, one response
//            consumer and the shared-ALU arbiter.
// Signals  : req0_* / req1_*  valid, a, b, ctrl (to arbiter), ready (from it)
//            rsp_*            valid, id, result, zero (from arbiter),
//                             ready (to arbiter)
//            busy             arbiter has an operation in flight
// Modports : slave  - the arbiter side
//            master - the requester/consumer side
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
interface alu_arbiter_if;

   logic        req0_valid;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [2:0]  req0_ctrl;
   logic        req0_ready;

   logic        req1_valid;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [2:0]  req1_ctrl;
   logic        req1_ready;

   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_zero;

   logic        busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_ctrl,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_ctrl,
      output req1_ready,
      output rsp_valid, rsp_id, rsp_result, rsp_zero,
      input  rsp_ready,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_ctrl,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_ctrl,
      input  req1_ready,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero,
      output rsp_ready,
      input  busy
   );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : alu_arbiter
// Purpose  : Shares one combinational 32-bit ALU between two requesters.
//            Arbitrates (round-robin or fixed priority), latches the winning
//            operands, executes, and returns a registered result tagged with
//            the requester id. One operation in flight at a time.
// Ports    : clk    - clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - alu_arbiter_if.slave (request/response handshakes, busy)
// Params   : FIXED_PRIO - 0: round-robin on ties, 1: requester 0 wins ties
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module alu_arbiter #(
   parameter int unsigned FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_arbiter_if.slave bus
);

   // ALU operation encodings; every code from 3'b100 up is unsigned set-less-than
   localparam logic [2:0] c_OP_ADD = 3'b000;
   localparam logic [2:0] c_OP_SUB = 3'b001;
   localparam logic [2:0] c_OP_AND = 3'b010;
   localparam logic [2:0] c_OP_OR  = 3'b011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic        r_last_grant;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [2:0]  r_ctrl;
   logic        r_id;
   logic [31:0] r_result;
   logic        r_zero;
   logic        r_rsp_valid;
   logic        r_busy;

   logic        w_grant_id;
   logic        w_accept;
   logic [31:0] w_alu_result;

   //---------------------------------------------------------------------------
   // Arbitration. On a tie the round-robin mode picks the requester that did
   // not win last time; last_grant resets to 1 so requester 0 wins the first
   // tie after reset.
   //---------------------------------------------------------------------------
   always_comb begin
      w_grant_id = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         w_grant_id = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
      end else if (bus.req1_valid) begin
         w_grant_id = 1'b1;
      end
   end

   // Accepting only from IDLE keeps a new request from overlapping the
   // response of the previous one.
   assign w_accept       = (r_state == ST_IDLE) && (bus.req0_valid || bus.req1_valid);
   assign bus.req0_ready = w_accept && !w_grant_id;
   assign bus.req1_ready = w_accept &&  w_grant_id;

   //---------------------------------------------------------------------------
   // Shared ALU, fed only from the latched operands so requester inputs can
   // change freely after the accept cycle.
   //---------------------------------------------------------------------------
   always_comb begin
      w_alu_result = '0;
      case (r_ctrl)
         c_OP_ADD: w_alu_result = r_a + r_b;
         c_OP_SUB: w_alu_result = r_a - r_b;
         c_OP_AND: w_alu_result = r_a & r_b;
         c_OP_OR:  w_alu_result = r_a | r_b;
         default:  w_alu_result = {31'd0, (r_a < r_b)};
      endcase
   end

   //---------------------------------------------------------------------------
   // Control FSM with registered response and busy outputs.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 1'b1;
         r_a          <= '0;
         r_b          <= '0;
         r_ctrl       <= '0;
         r_id         <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b0;
         r_rsp_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_a          <= w_grant_id ? bus.req1_a    : bus.req0_a;
                  r_b          <= w_grant_id ? bus.req1_b    : bus.req0_b;
                  r_ctrl       <= w_grant_id ? bus.req1_ctrl : bus.req0_ctrl;
                  r_id         <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_busy       <= 1'b1;
                  r_state      <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               r_result    <= w_alu_result;
               r_zero      <= (w_alu_result == 32'd0);
               r_rsp_valid <= 1'b1;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               // Response fields hold their values until the consumer takes them
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_id     = r_id;
   assign bus.rsp_result = r_result;
   assign bus.rsp_zero   = r_zero;
   assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_alu_arbiter
// Purpose  : Directed self-checking bench for alu_arbiter. Two instances
//            (round-robin and fixed priority) see identical stimulus.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
module tb_alu_arbiter;

   logic        clk;
   logic        rst_n;

   logic        v0, v1, rr;
   logic [31:0] a0, b0, a1, b1;
   logic [2:0]  c0, c1;

   int          errors;
   int          checks;

   alu_arbiter_if ifa ();
   alu_arbiter_if ifb ();

   assign ifa.req0_valid = v0;  assign ifb.req0_valid = v0;
   assign ifa.req0_a     = a0;  assign ifb.req0_a     = a0;
   assign ifa.req0_b     = b0;  assign ifb.req0_b     = b0;
   assign ifa.req0_ctrl  = c0;  assign ifb.req0_ctrl  = c0;
   assign ifa.req1_valid = v1;  assign ifb.req1_valid = v1;
   assign ifa.req1_a     = a1;  assign ifb.req1_a     = a1;
   assign ifa.req1_b     = b1;  assign ifb.req1_b     = b1;
   assign ifa.req1_ctrl  = c1;  assign ifb.req1_ctrl  = c1;
   assign ifa.rsp_ready  = rr;  assign ifb.rsp_ready  = rr;

   alu_arbiter #(.FIXED_PRIO(0)) u_dut_rr (.clk(clk), .rst_n(rst_n), .bus(ifa));
   alu_arbiter #(.FIXED_PRIO(1)) u_dut_fp (.clk(clk), .rst_n(rst_n), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One uncontended operation with rsp_ready held high; starts and ends at a
   // falling edge with the DUT idle.
   task automatic run_op(input string tag, input logic id, input logic [31:0] a,
                         input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] er, input logic ez);
      @(negedge clk);
      rr = 1'b1;
      if (!id) begin v0 = 1'b1; a0 = a; b0 = b; c0 = c; end
      else     begin v1 = 1'b1; a1 = a; b1 = b; c1 = c; end
      #1;
      chk({tag, "_rdy0"}, ifa.req0_ready, {31'd0, !id});
      chk({tag, "_rdy1"}, ifa.req1_ready, {31'd0, id});
      chk({tag, "_busy_T"}, ifa.busy, 0);
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      chk({tag, "_busy_exec"}, ifa.busy, 1);
      chk({tag, "_vld_exec"}, ifa.rsp_valid, 0);
      @(negedge clk);
      chk({tag, "_vld"}, ifa.rsp_valid, 1);
      chk({tag, "_id"}, ifa.rsp_id, {31'd0, id});
      chk({tag, "_res"}, ifa.rsp_result, er);
      chk({tag, "_zero"}, ifa.rsp_zero, {31'd0, ez});
      @(negedge clk);
      chk({tag, "_vld_done"}, ifa.rsp_valid, 0);
      chk({tag, "_busy_done"}, ifa.busy, 0);
   endtask

   initial begin
      errors = 0; checks = 0;
      rst_n = 1'b0; rr = 1'b0;
      v0 = 1'b0; a0 = '0; b0 = '0; c0 = '0;
      v1 = 1'b0; a1 = '0; b1 = '0; c1 = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_rdy0",  ifa.req0_ready, 0);
      chk("rst_rdy1",  ifa.req1_ready, 0);
      chk("rst_vld",   ifa.rsp_valid,  0);
      chk("rst_id",    ifa.rsp_id,     0);
      chk("rst_res",   ifa.rsp_result, 0);
      chk("rst_zero",  ifa.rsp_zero,   0);
      chk("rst_busy",  ifa.busy,       0);
      rst_n = 1'b1;

      // Single op and ALU edge cases
      run_op("sub",  1'b0, 32'd5,          32'd3,      3'b001, 32'd2,      1'b0);
      run_op("addw", 1'b0, 32'hFFFF_FFFF,  32'd1,      3'b000, 32'd0,      1'b1);
      run_op("and",  1'b0, 32'h0000_F0F0,  32'h0FF0,   3'b010, 32'h00F0,   1'b0);
      run_op("or",   1'b0, 32'h0000_F0F0,  32'h0FF0,   3'b011, 32'hFFF0,   1'b0);
      run_op("slt",  1'b0, 32'd2,          32'd3,      3'b100, 32'd1,      1'b0);
      run_op("sltu", 1'b1, 32'hFFFF_FFFF,  32'd1,      3'b111, 32'd0,      1'b1);

      // Contention: last grant was requester 1, so round-robin gives 0,1,0,1
      @(negedge clk);
      rr = 1'b1;
      v0 = 1'b1; a0 = 32'd10; b0 = 32'd1; c0 = 3'b000;
      v1 = 1'b1; a1 = 32'd20; b1 = 32'd2; c1 = 3'b001;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk($sformatf("rr_rdy0_%0d", k), ifa.req0_ready, (k % 2 == 0) ? 1 : 0);
         chk($sformatf("rr_rdy1_%0d", k), ifa.req1_ready, (k % 2 == 1) ? 1 : 0);
         chk($sformatf("fp_rdy0_%0d", k), ifb.req0_ready, 1);
         chk($sformatf("fp_rdy1_%0d", k), ifb.req1_ready, 0);
         @(negedge clk);
         chk($sformatf("rr_rdy_exec_%0d", k), {ifa.req0_ready, ifa.req1_ready}, 0);
         @(negedge clk);
         chk($sformatf("rr_rdy_resp_%0d", k), {ifa.req0_ready, ifa.req1_ready}, 0);
         chk($sformatf("rr_id_%0d", k),  ifa.rsp_id,     (k % 2 == 1) ? 1 : 0);
         chk($sformatf("rr_res_%0d", k), ifa.rsp_result, (k % 2 == 1) ? 18 : 11);
         chk($sformatf("fp_id_%0d", k),  ifb.rsp_id,     0);
         chk($sformatf("fp_res_%0d", k), ifb.rsp_result, 11);
         @(negedge clk);
      end
      v0 = 1'b0; v1 = 1'b0;

      // Backpressure: response held with rsp_ready low while req1 waits
      @(negedge clk);
      rr = 1'b0;
      v0 = 1'b1; a0 = 32'd7; b0 = 32'd7; c0 = 3'b001;
      #1;
      chk("bp_rdy0", ifa.req0_ready, 1);
      @(negedge clk);
      v0 = 1'b0;
      v1 = 1'b1; a1 = 32'd100; b1 = 32'd1; c1 = 3'b000;
      chk("bp_rdy1_exec", ifa.req1_ready, 0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bp_vld_%0d", k),  ifa.rsp_valid,  1);
         chk($sformatf("bp_res_%0d", k),  ifa.rsp_result, 0);
         chk($sformatf("bp_zero_%0d", k), ifa.rsp_zero,   1);
         chk($sformatf("bp_id_%0d", k),   ifa.rsp_id,     0);
         chk($sformatf("bp_rdy_%0d", k),  {ifa.req0_ready, ifa.req1_ready}, 0);
         chk($sformatf("bp_busy_%0d", k), ifa.busy,       1);
      end
      rr = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_vld_after", ifa.rsp_valid,  0);
      chk("bp_rdy1_acc",  ifa.req1_ready, 1);
      @(negedge clk);
      v1 = 1'b0;
      @(negedge clk);
      chk("bp_r1_id",  ifa.rsp_id,     1);
      chk("bp_r1_res", ifa.rsp_result, 101);
      @(negedge clk);

      // Operand stability: inputs changed right after accept are ignored
      v0 = 1'b1; a0 = 32'd9; b0 = 32'd4; c0 = 3'b000;
      #1;
      chk("stab_rdy0", ifa.req0_ready, 1);
      @(negedge clk);
      v0 = 1'b0; a0 = 32'd1000; b0 = 32'd1000; c0 = 3'b001;
      @(negedge clk);
      chk("stab_res",  ifa.rsp_result, 13);
      chk("stab_zero", ifa.rsp_zero,   0);
      @(negedge clk);

      // Async reset mid-EXEC (last grant is requester 0 before reset)
      v0 = 1'b1; a0 = 32'd1; b0 = 32'd1; c0 = 3'b000;
      @(negedge clk);
      v0 = 1'b0;
      chk("arx_busy_pre", ifa.busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arx_busy", ifa.busy,      0);
      chk("arx_vld",  ifa.rsp_valid, 0);
      @(negedge clk);
      rst_n = 1'b1;
      v0 = 1'b1; v1 = 1'b1; a0 = 32'd3; b0 = 32'd3; c0 = 3'b001;
      #1;
      chk("arx_tie_rdy0", ifa.req0_ready, 1);
      chk("arx_tie_rdy1", ifa.req1_ready, 0);
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0; rr = 1'b0;
      @(negedge clk);

      // Async reset mid-RESP
      chk("arr_vld_pre",  ifa.rsp_valid,  1);
      chk("arr_zero_pre", ifa.rsp_zero,   1);
      #2 rst_n = 1'b0;
      #1;
      chk("arr_vld",  ifa.rsp_valid,  0);
      chk("arr_busy", ifa.busy,       0);
      chk("arr_zero", ifa.rsp_zero,   0);
      @(negedge clk);
      rst_n = 1'b1; rr = 1'b1;
      v0 = 1'b1; v1 = 1'b1;
      #1;
      chk("arr_tie_rdy0", ifa.req0_ready, 1);
      chk("arr_tie_rdy1", ifa.req1_ready, 0);
      @(negedge clk);
      v0 = 1'b0; v1 = 1'b0;
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
